layer_controller: RTL and testbench

- Sequences one fully-connected layer of `numNeurons` neuron instances that share a broadcast input.
- Accepts an input vector from upstream over a valid/ready stream and buffers it.
- Clears the neurons, pulses their start, then replays the vector one element per cycle. It collects every neuron result and serialises the results downstream.
- Also decodes the configuration bus into per-neuron weight/bias write enables while the layer is idle.

---
 rtl/layer_controller.sv | 252 +++++++++++++++++++++++++
 tb/tb_layer_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_controller.sv
// layer_controller: buffers one input vector, clears/starts the neuron array, streams the vector,
// collects per-neuron results and serialises them downstream. Defining LAYER_TIMEOUT_EN adds a WAIT watchdog.
module layer_controller #(
  parameter int unsigned layerNumber   = 0,
  parameter int unsigned numNeurons    = 16,
  parameter int unsigned numInputs     = 256,
  parameter int unsigned dataWidth     = 8,
  parameter int unsigned timeoutCycles = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [dataWidth-1:0]            in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            neuron_clear,
  output logic                            neuron_valid,
  output logic [dataWidth-1:0]            neuron_in,
  input  logic [numNeurons*dataWidth-1:0] neuron_out_bus,
  input  logic [numNeurons-1:0]           neuron_out_valid,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic                            cfg_is_bias,
  input  logic [31:0]                     cfg_layer,
  input  logic [31:0]                     cfg_neuron,
  input  logic [31:0]                     cfg_data,
  output logic [numNeurons-1:0]           weight_write_en,
  output logic [numNeurons-1:0]           bias_write_en,
  output logic [31:0]                     cfg_data_out,
  output logic                            busy,
  output logic                            timeout_err
);

  localparam int unsigned MAXN = (numInputs > numNeurons) ? numInputs : numNeurons;
  localparam int unsigned IW   = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam logic [IW-1:0] LAST_IN = IW'(numInputs - 1);
  localparam logic [IW-1:0] LAST_NR = IW'(numNeurons - 1);

  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, START, STREAM, WAIT, DRAIN} state_e;

  state_e                 st_q, st_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [numNeurons-1:0]  mask_q, mask_d;
  logic [dataWidth-1:0]   result_q [numNeurons];
  logic [dataWidth-1:0]   result_d [numNeurons];
  logic [dataWidth-1:0]   buf_mem  [numInputs];
  logic                   buf_we;

  logic                   in_ready_q, in_ready_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic                   neuron_clear_q, neuron_clear_d;
  logic                   neuron_valid_q, neuron_valid_d;
  logic [dataWidth-1:0]   neuron_in_q, neuron_in_d;
  logic [dataWidth-1:0]   out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic [numNeurons-1:0]  weight_we_q, weight_we_d;
  logic [numNeurons-1:0]  bias_we_q, bias_we_d;
  logic [31:0]            cfg_data_out_q, cfg_data_out_d;
  logic                   busy_q, busy_d;

  logic                   in_hs, cfg_hs, out_hs, cfg_hit;
  logic [numNeurons-1:0]  cfg_onehot;
  logic [dataWidth-1:0]   stream_sel, drain_sel;

`ifdef LAYER_TIMEOUT_EN
  localparam int unsigned WW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
  localparam logic [WW-1:0] WLAST = WW'(timeoutCycles - 1);
  logic [WW-1:0]          wcnt_q, wcnt_d;
  logic                   terr_q, terr_d;
  assign timeout_err = terr_q;
`else
  localparam int unsigned unused_timeout_cycles = timeoutCycles;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    st_d     = st_q;
    idx_d    = idx_q;
    mask_d   = mask_q;
    result_d = result_q;
    buf_we   = 1'b0;
    in_hs    = in_valid & in_ready_q;
    cfg_hs   = cfg_valid & cfg_ready_q;
    out_hs   = out_valid_q & out_ready;
`ifdef LAYER_TIMEOUT_EN
    wcnt_d   = '0;
    terr_d   = terr_q;
`endif

    case (st_q)
      IDLE, LOAD: begin
        if (in_hs) begin
          buf_we = 1'b1;
          if (idx_q == LAST_IN) begin
            st_d  = CLEAR;
            idx_d = '0;
          end else begin
            st_d  = LOAD;
            idx_d = idx_q + IW'(1);
          end
        end
      end
      CLEAR: st_d = START;
      START: begin
        st_d  = STREAM;
        idx_d = '0;
      end
      STREAM: begin
        if (idx_q == LAST_IN) begin
          st_d  = WAIT;
          idx_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      WAIT: begin
        // only the first valid per neuron is captured; repeats are ignored
        for (int unsigned n = 0; n < numNeurons; n++) begin
          if (neuron_out_valid[n] && !mask_q[n]) begin
            mask_d[n]   = 1'b1;
            result_d[n] = neuron_out_bus[n*dataWidth +: dataWidth];
          end
        end
        if (&mask_d) begin
          st_d  = DRAIN;
          idx_d = '0;
        end
`ifdef LAYER_TIMEOUT_EN
        else if (wcnt_q == WLAST) begin
          st_d   = DRAIN;
          idx_d  = '0;
          terr_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
`endif
      end
      DRAIN: begin
        if (out_hs) begin
          if (idx_q == LAST_NR) begin
            st_d   = IDLE;
            idx_d  = '0;
            mask_d = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: st_d = IDLE;
    endcase

    stream_sel = '0;
    for (int unsigned k = 0; k < numInputs; k++) begin
      if (idx_d == IW'(k)) stream_sel = buf_mem[k];
    end
    // results never captured (watchdog exit) drain as zero
    drain_sel = '0;
    for (int unsigned n = 0; n < numNeurons; n++) begin
      if (idx_d == IW'(n) && mask_d[n]) drain_sel = result_d[n];
    end

    cfg_hit = cfg_hs && (cfg_layer == 32'(layerNumber)) && (cfg_neuron < 32'(numNeurons));
    cfg_onehot = '0;
    for (int unsigned n = 0; n < numNeurons; n++) begin
      cfg_onehot[n] = cfg_hit && (cfg_neuron == 32'(n));
    end
    weight_we_d    = cfg_is_bias ? '0 : cfg_onehot;
    bias_we_d      = cfg_is_bias ? cfg_onehot : '0;
    cfg_data_out_d = cfg_hit ? cfg_data : cfg_data_out_q;

    // outputs are registered from the next state so they line up with the state they describe
    in_ready_d     = (st_d == IDLE) || (st_d == LOAD);
    cfg_ready_d    = (st_d == IDLE);
    neuron_clear_d = (st_d == CLEAR);
    neuron_valid_d = (st_d == START);
    neuron_in_d    = (st_d == STREAM) ? stream_sel : neuron_in_q;
    out_valid_d    = (st_d == DRAIN);
    out_last_d     = (st_d == DRAIN) && (idx_d == LAST_NR);
    out_data_d     = (st_d == DRAIN) ? drain_sel : '0;
    busy_d         = (st_d != IDLE);
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < numInputs; k++) begin
      if (buf_we && idx_q == IW'(k)) buf_mem[k] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      idx_q  <= '0;
      mask_q <= '0;
      for (int unsigned n = 0; n < numNeurons; n++) result_q[n] <= '0;
      in_ready_q     <= 1'b0;
      cfg_ready_q    <= 1'b0;
      neuron_clear_q <= 1'b0;
      neuron_valid_q <= 1'b0;
      neuron_in_q    <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      weight_we_q    <= '0;
      bias_we_q      <= '0;
      cfg_data_out_q <= '0;
      busy_q         <= 1'b0;
`ifdef LAYER_TIMEOUT_EN
      wcnt_q <= '0;
      terr_q <= 1'b0;
`endif
    end else begin
      st_q     <= st_d;
      idx_q    <= idx_d;
      mask_q   <= mask_d;
      result_q <= result_d;
      in_ready_q     <= in_ready_d;
      cfg_ready_q    <= cfg_ready_d;
      neuron_clear_q <= neuron_clear_d;
      neuron_valid_q <= neuron_valid_d;
      neuron_in_q    <= neuron_in_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      weight_we_q    <= weight_we_d;
      bias_we_q      <= bias_we_d;
      cfg_data_out_q <= cfg_data_out_d;
      busy_q         <= busy_d;
`ifdef LAYER_TIMEOUT_EN
      wcnt_q <= wcnt_d;
      terr_q <= terr_d;
`endif
    end
  end

  assign in_ready        = in_ready_q;
  assign cfg_ready       = cfg_ready_q;
  assign neuron_clear    = neuron_clear_q;
  assign neuron_valid    = neuron_valid_q;
  assign neuron_in       = neuron_in_q;
  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;
  assign out_last        = out_last_q;
  assign weight_write_en = weight_we_q;
  assign bias_write_en   = bias_we_q;
  assign cfg_data_out    = cfg_data_out_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_layer_controller.sv
// Self-checking bench for layer_controller: config decode table, directed layer passes and
// randomized passes checked against a per-neuron first-capture model.
module tb_layer_controller;
  localparam int unsigned NN = 4;
  localparam int unsigned NI = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned LN = 2;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]    in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             neuron_clear, neuron_valid;
  logic [DW-1:0]    neuron_in;
  logic [NN*DW-1:0] neuron_out_bus = '0;
  logic [NN-1:0]    neuron_out_valid = '0;
  logic [DW-1:0]    out_data;
  logic             out_valid, out_last;
  logic             out_ready = 1'b0;
  logic             cfg_valid = 1'b0, cfg_ready, cfg_is_bias = 1'b0;
  logic [31:0]      cfg_layer = '0, cfg_neuron = '0, cfg_data = '0;
  logic [NN-1:0]    weight_write_en, bias_write_en;
  logic [31:0]      cfg_data_out;
  logic             busy, timeout_err;

  layer_controller #(
    .layerNumber(LN), .numNeurons(NN), .numInputs(NI), .dataWidth(DW), .timeoutCycles(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .neuron_clear(neuron_clear), .neuron_valid(neuron_valid), .neuron_in(neuron_in),
    .neuron_out_bus(neuron_out_bus), .neuron_out_valid(neuron_out_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_is_bias(cfg_is_bias),
    .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .cfg_data(cfg_data),
    .weight_write_en(weight_write_en), .bias_write_en(bias_write_en),
    .cfg_data_out(cfg_data_out), .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          is_bias;
    logic [31:0]   layer;
    logic [31:0]   neuron;
    logic [31:0]   data;
    logic [NN-1:0] ew;
    logic [NN-1:0] eb;
  } cfg_vec_t;
  cfg_vec_t tbl [6];

  // stimulus / model state for one layer pass
  logic [DW-1:0] vec  [NI];
  int            off1 [NN];
  int            off2 [NN];
  logic [DW-1:0] val1 [NN];
  logic [DW-1:0] val2 [NN];
  int            lows [NN];
  bit            use_gaps;
  bit            exp_terr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input int first);
    int budget;
    bit hs;
    for (int k = first; k < int'(NI); k++) begin
      if (use_gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      in_valid = 1'b1;
      in_data  = vec[k];
      budget   = 0;
      forever begin
        hs = in_ready;
        step();
        if (hs) break;
        budget++;
        if (budget > 20) begin
          chk("in_accept_timeout", 1, 0);
          in_valid = 1'b0;
          return;
        end
      end
      if (k == 0) chk("cfg_ready_load", cfg_ready, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic check_stream;
    chk("neuron_clear", neuron_clear, 1);
    chk("in_ready_clear", in_ready, 0);
    chk("busy_clear", busy, 1);
    step();
    chk("neuron_valid", neuron_valid, 1);
    chk("neuron_clear_off", neuron_clear, 0);
    for (int k = 0; k < int'(NI); k++) begin
      step();
      chk("neuron_in", neuron_in, vec[k]);
      if (k == 0) chk("neuron_valid_off", neuron_valid, 0);
    end
    step();
  endtask

  task automatic wait_and_drain;
    int first_off [NN];
    logic [DW-1:0] first_val [NN];
    logic [DW-1:0] exp_res [NN];
    int  m = 0;
    bit  all_seen = 1'b1;
    int  drain_w;
    for (int n = 0; n < int'(NN); n++) begin
      first_off[n] = -1;
      first_val[n] = '0;
      if (off1[n] >= 0) begin first_off[n] = off1[n]; first_val[n] = val1[n]; end
      if (off2[n] >= 0 && (first_off[n] < 0 || off2[n] < first_off[n])) begin
        first_off[n] = off2[n];
        first_val[n] = val2[n];
      end
      if (first_off[n] < 0) all_seen = 1'b0;
      else if (first_off[n] > m) m = first_off[n];
    end
`ifdef LAYER_TIMEOUT_EN
    if (all_seen && m <= int'(TO) - 1) drain_w = m + 1;
    else begin
      drain_w  = int'(TO);
      exp_terr = 1'b1;
    end
`else
    drain_w = m + 1;
`endif
    for (int n = 0; n < int'(NN); n++)
      exp_res[n] = (first_off[n] >= 0 && first_off[n] < drain_w) ? first_val[n] : '0;

    for (int w = 0; w <= drain_w; w++) begin
      chk("out_valid_wait", out_valid, (w == drain_w));
      for (int n = 0; n < int'(NN); n++) begin
        neuron_out_valid[n] = (w < drain_w) && ((off1[n] == w) || (off2[n] == w));
        neuron_out_bus[n*DW +: DW] = (off2[n] == w) ? val2[n] : val1[n];
      end
      if (w < drain_w) step();
    end
    neuron_out_valid = '0;

    for (int i = 0; i < int'(NN); i++) begin
      for (int c = 0; c <= lows[i]; c++) begin
        out_ready = (c == lows[i]);
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, exp_res[i]);
        chk("out_last", out_last, (i == int'(NN) - 1));
        step();
      end
    end
    out_ready = 1'b0;
    chk("out_valid_done", out_valid, 0);
    chk("busy_done", busy, 0);
    chk("in_ready_done", in_ready, 1);
    chk("timeout_err", timeout_err, exp_terr);
  endtask

  task automatic set_plain_sched;
    for (int n = 0; n < int'(NN); n++) begin
      off1[n] = n % 2;
      off2[n] = -1;
      val1[n] = DW'(8'h10 * (n + 1) + n);
      val2[n] = '0;
      lows[n] = 0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 32'(LN),     32'd3,          32'h5A, 4'b1000, 4'b0000};
    tbl[1] = '{1'b0, 32'(LN + 1), 32'd3,          32'h5A, 4'b0000, 4'b0000};
    tbl[2] = '{1'b1, 32'(LN),     32'd0,          32'hA5, 4'b0000, 4'b0001};
    tbl[3] = '{1'b1, 32'(LN),     32'd4,          32'h11, 4'b0000, 4'b0000};
    tbl[4] = '{1'b0, 32'(LN),     32'd1,          32'h3C, 4'b0010, 4'b0000};
    tbl[5] = '{1'b1, 32'(LN),     32'h8000_0002,  32'h77, 4'b0000, 4'b0000};

    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_neuron_in", neuron_in, 0);
    #10 reset = 1'b1;
    step();
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      cfg_valid   = 1'b1;
      cfg_is_bias = tbl[i].is_bias;
      cfg_layer   = tbl[i].layer;
      cfg_neuron  = tbl[i].neuron;
      cfg_data    = tbl[i].data;
      step();
      cfg_valid = 1'b0;
      chk("cfg_weight_en", weight_write_en, tbl[i].ew);
      chk("cfg_bias_en", bias_write_en, tbl[i].eb);
      if ((tbl[i].ew | tbl[i].eb) != '0) chk("cfg_data_out", cfg_data_out, tbl[i].data);
      step();
      chk("cfg_weight_en_off", weight_write_en, 0);
      chk("cfg_bias_en_off", bias_write_en, 0);
    end

    // directed pass: simultaneous cfg + first element, gaps, staggered/repeated valids, backpressure
    vec[0] = 8'd1; vec[1] = 8'd2; vec[2] = 8'd3; vec[3] = 8'd4;
    set_plain_sched();
    off1[1] = 0; val1[1] = 8'h22; off2[1] = 2; val2[1] = 8'h99;
    off1[0] = 3; val1[0] = 8'h11;
    off1[2] = 1; val1[2] = 8'h33;
    off1[3] = 2; val1[3] = 8'h44;
    lows[0] = 5; lows[3] = 5;
    use_gaps = 1'b1;
    cfg_valid = 1'b1; cfg_is_bias = 1'b0; cfg_layer = 32'(LN); cfg_neuron = 32'd2; cfg_data = 32'h77;
    in_valid = 1'b1; in_data = vec[0];
    step();
    cfg_valid = 1'b0; in_valid = 1'b0;
    chk("sim_cfg_weight_en", weight_write_en, 4'b0100);
    chk("sim_cfg_data_out", cfg_data_out, 32'h77);
    chk("sim_cfg_ready", cfg_ready, 0);
    chk("sim_busy", busy, 1);
    send_vec(1);
    check_stream();
    wait_and_drain();

    // reset in the middle of STREAM
    vec[0] = 8'hA1; vec[1] = 8'hB2; vec[2] = 8'hC3; vec[3] = 8'hD4;
    use_gaps = 1'b0;
    send_vec(0);
    step();
    step();
    step();
    #2 reset = 1'b0;
    #1;
    chk("mrst_neuron_in", neuron_in, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_neuron_valid", neuron_valid, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_cfg_data_out", cfg_data_out, 0);
    #1 reset = 1'b1;
    exp_terr = 1'b0;
    step();
    vec[0] = 8'h05; vec[1] = 8'h06; vec[2] = 8'h07; vec[3] = 8'h08;
    set_plain_sched();
    send_vec(0);
    check_stream();
    wait_and_drain();

`ifdef LAYER_TIMEOUT_EN
    vec[0] = 8'h0F; vec[1] = 8'h1E; vec[2] = 8'h2D; vec[3] = 8'h3C;
    set_plain_sched();
    off1[1] = -1;
    send_vec(0);
    check_stream();
    wait_and_drain();
    set_plain_sched();
    send_vec(0);
    check_stream();
    wait_and_drain();
`endif

    // randomized passes
    use_gaps = 1'b1;
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < int'(NI); k++) vec[k] = DW'($urandom);
      for (int n = 0; n < int'(NN); n++) begin
        off1[n] = int'($urandom_range(0, 5));
        off2[n] = ($urandom_range(0, 1) == 1) ? off1[n] + 1 + int'($urandom_range(0, 3)) : -1;
        val1[n] = DW'($urandom);
        val2[n] = DW'($urandom);
        lows[n] = int'($urandom_range(0, 2));
      end
      send_vec(0);
      check_stream();
      wait_and_drain();
    end

`ifdef LAYER_TIMEOUT_EN
    #2 reset = 1'b0;
    #1 chk("terr_cleared", timeout_err, 0);
    #1 reset = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
